// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the CPU pipeline.
// Holds the memory-op encoding, the write-back source codes and the
// datapath width constants used by mem_wb_stage and data_mem.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MEM_OP_W  = 4;
  localparam int REG_SRC_W = 2;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_NONE = 4'd0,
    MEM_LW   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LHU  = 4'd3,
    MEM_LB   = 4'd4,
    MEM_LBU  = 4'd5,
    MEM_SW   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SB   = 4'd8
  } mem_op_e;

  localparam logic [REG_SRC_W-1:0] REG_SRC_ALU  = 2'd0;
  localparam logic [REG_SRC_W-1:0] REG_SRC_LOAD = 2'd1;
  localparam logic [REG_SRC_W-1:0] REG_SRC_PC4  = 2'd2;

  // True for the three store opcodes.
  function automatic logic is_store(input mem_op_e op);
    logic r;
    case (op)
      MEM_SW, MEM_SH, MEM_SB: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// data_mem -- word-organised data memory with per-byte write enables.
// Ports:
//   clk    rising-edge clock
//   we     write enable (already qualified by stall/flush/reset upstream)
//   be     byte-lane enables, bit i covers bits 8*i+7:8*i
//   addr   word index, shared by the write port and the read port
//   wdata  lane-replicated write data
//   rdata  combinational read of the addressed word
// The array dataMem starts at zero and is never cleared by reset.
module data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] dataMem [DEPTH_WORDS] = '{default: 32'h0000_0000};

  // Byte-lane write; lanes without an enable keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          dataMem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Asynchronous read so loads resolve within the MEM cycle.
  assign rdata = dataMem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- MEM stage (data memory access) plus the MEM/WB register.
// Inputs come from the MEM stage (mem_*), control from the hazard unit
// (stall, flush); outputs drive the register-file write port (wb_*).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall               hold MEM/WB and block stores
//   flush               push a bubble into WB (wins over stall)
//   mem_valid/pc        MEM instruction qualifier and PC
//   mem_alu_result      ALU result / effective address
//   mem_store_data      store source (rt)
//   mem_op              cpu_pkg::mem_op_e encoding
//   mem_reg_write/rd    destination write request and register
//   mem_reg_src         WB source select (ALU, load, PC+4)
//   wb_valid/pc/rd      registered WB instruction fields
//   wb_reg_write        register-file write enable
//   wb_write_data       registered register-file write data
//   wb_misaligned       misaligned-access flag
// Build option: define MISALIGN_TRAP_EN to trap misaligned LW/LH/LHU/SW/SH
// (store suppressed, no register write, wb_misaligned set). Without it the
// low address bits are forced to alignment and wb_misaligned is 0.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic [XLEN-1:0]       mem_pc,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic [XLEN-1:0]       mem_store_data,
  input  logic [MEM_OP_W-1:0]   mem_op,
  input  logic                  mem_reg_write,
  input  logic [REG_SRC_W-1:0]  mem_reg_src,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic [XLEN-1:0]       wb_pc,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_write_data,
  output logic                  wb_misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_op_e              op_s;
  logic [1:0]           off_s;
  logic                 trap_s;
  logic                 we_s;
  logic [3:0]           be_s;
  logic [31:0]          wdata_s;
  logic [31:0]          rdata_s;
  logic [15:0]          half_s;
  logic [7:0]           byte_s;
  logic [31:0]          load_s;
  logic [31:0]          wb_data_s;

  logic                  wb_valid_r;
  logic [XLEN-1:0]       wb_pc_r;
  logic                  wb_reg_write_r;
  logic [REG_ADDR_W-1:0] wb_rd_r;
  logic [XLEN-1:0]       wb_write_data_r;

  assign op_s = mem_op_e'(mem_op);

`ifdef MISALIGN_TRAP_EN
  logic misaligned_s;
  logic wb_misaligned_r;

  // Misalignment detection; the raw offset is kept for lane selection.
  always_comb begin
    misaligned_s = 1'b0;
    off_s        = mem_alu_result[1:0];
    case (op_s)
      MEM_LW, MEM_SW:          misaligned_s = (mem_alu_result[1:0] != 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: misaligned_s = mem_alu_result[0];
      default:                 misaligned_s = 1'b0;
    endcase
  end

  assign trap_s = misaligned_s;
`else
  // Force the offset to the access size's natural alignment.
  always_comb begin
    off_s = mem_alu_result[1:0];
    case (op_s)
      MEM_LW, MEM_SW:          off_s = 2'b00;
      MEM_LH, MEM_LHU, MEM_SH: off_s = {mem_alu_result[1], 1'b0};
      default:                 off_s = mem_alu_result[1:0];
    endcase
  end

  assign trap_s = 1'b0;
`endif

  // rst is folded in so a store in flight at a reset edge is dropped.
  assign we_s = mem_valid & is_store(op_s) & ~stall & ~flush & ~rst & ~trap_s;

  // Byte enables and lane-replicated store data; SH/SB use the low bits.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = mem_store_data;
    case (op_s)
      MEM_SW: begin
        be_s = 4'b1111;
      end
      MEM_SH: begin
        wdata_s = {2{mem_store_data[15:0]}};
        if (off_s[1]) begin
          be_s = 4'b1100;
        end else begin
          be_s = 4'b0011;
        end
      end
      MEM_SB: begin
        wdata_s = {4{mem_store_data[7:0]}};
        be_s    = 4'b0001 << off_s;
      end
      default: begin
        be_s = 4'b0000;
      end
    endcase
  end

  data_mem #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem (
    .clk  (clk),
    .we   (we_s),
    .be   (be_s),
    .addr (mem_alu_result[AW+1:2]),
    .wdata(wdata_s),
    .rdata(rdata_s)
  );

  // Little-endian lane extraction and sign/zero extension.
  always_comb begin
    half_s = 16'h0000;
    byte_s = 8'h00;
    load_s = 32'h0000_0000;
    if (off_s[1]) begin
      half_s = rdata_s[31:16];
    end else begin
      half_s = rdata_s[15:0];
    end
    case (off_s)
      2'd0:    byte_s = rdata_s[7:0];
      2'd1:    byte_s = rdata_s[15:8];
      2'd2:    byte_s = rdata_s[23:16];
      2'd3:    byte_s = rdata_s[31:24];
      default: byte_s = 8'h00;
    endcase
    case (op_s)
      MEM_LW:  load_s = rdata_s;
      MEM_LH:  load_s = {{16{half_s[15]}}, half_s};
      MEM_LHU: load_s = {16'h0000, half_s};
      MEM_LB:  load_s = {{24{byte_s[7]}}, byte_s};
      MEM_LBU: load_s = {24'h00_0000, byte_s};
      default: load_s = 32'h0000_0000;
    endcase
  end

  // Write-back source select, resolved before the register so the output
  // comes straight from a flop.
  always_comb begin
    wb_data_s = 32'h0000_0000;
    case (mem_reg_src)
      REG_SRC_ALU:  wb_data_s = mem_alu_result;
      REG_SRC_LOAD: wb_data_s = load_s;
      REG_SRC_PC4:  wb_data_s = mem_pc + 32'd4;
      default:      wb_data_s = 32'h0000_0000;
    endcase
  end

  // MEM/WB pipeline register: flush beats stall, stall holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_r      <= 1'b0;
      wb_pc_r         <= 32'h0000_0000;
      wb_reg_write_r  <= 1'b0;
      wb_rd_r         <= 5'd0;
      wb_write_data_r <= 32'h0000_0000;
    end else if (flush) begin
      wb_valid_r      <= 1'b0;
      wb_pc_r         <= 32'h0000_0000;
      wb_reg_write_r  <= 1'b0;
      wb_rd_r         <= 5'd0;
      wb_write_data_r <= 32'h0000_0000;
    end else if (!stall) begin
      wb_valid_r      <= mem_valid;
      wb_pc_r         <= mem_pc;
      wb_reg_write_r  <= mem_valid & mem_reg_write & (mem_rd != 5'd0) & ~trap_s;
      wb_rd_r         <= mem_rd;
      wb_write_data_r <= wb_data_s;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Flag follows its instruction through the same register rules.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_misaligned_r <= 1'b0;
    end else if (flush) begin
      wb_misaligned_r <= 1'b0;
    end else if (!stall) begin
      wb_misaligned_r <= mem_valid & misaligned_s;
    end
  end

  assign wb_misaligned = wb_misaligned_r;
`else
  assign wb_misaligned = 1'b0;
`endif

  assign wb_valid      = wb_valid_r;
  assign wb_pc         = wb_pc_r;
  assign wb_reg_write  = wb_reg_write_r;
  assign wb_rd         = wb_rd_r;
  assign wb_write_data = wb_write_data_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage -- directed self-checking bench for mem_wb_stage.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_mem_wb_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_store_data;
  logic [3:0]  mem_op;
  logic        mem_reg_write;
  logic [1:0]  mem_reg_src;
  logic [4:0]  mem_rd;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_write_data;
  logic        wb_misaligned;

  int total = 0;
  int bad   = 0;

  mem_wb_stage #(.DEPTH_WORDS(1024)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_pc        (mem_pc),
    .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data),
    .mem_op        (mem_op),
    .mem_reg_write (mem_reg_write),
    .mem_reg_src   (mem_reg_src),
    .mem_rd        (mem_rd),
    .wb_valid      (wb_valid),
    .wb_pc         (wb_pc),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_write_data (wb_write_data),
    .wb_misaligned (wb_misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] rd,
                       input logic rw, input logic [1:0] src,
                       input logic [31:0] pc);
    mem_valid      = 1'b1;
    mem_op         = op;
    mem_alu_result = addr;
    mem_store_data = sdata;
    mem_rd         = rd;
    mem_reg_write  = rw;
    mem_reg_src    = src;
    mem_pc         = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", wb_valid); end
    total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL reset_rw got=%0h exp=0", wb_reg_write); end
    total++; if (wb_write_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", wb_write_data); end
    total++; if (wb_pc !== 32'h0 || wb_rd !== 5'd0 || wb_misaligned !== 1'b0) begin bad++; $display("FAIL reset_fields pc=%h rd=%0d mis=%0b exp=0", wb_pc, wb_rd, wb_misaligned); end
    total++; if (dut.u_mem.dataMem[0] !== 32'h0 || dut.u_mem.dataMem[1023] !== 32'h0) begin bad++; $display("FAIL reset_mem got=%h/%h exp=0", dut.u_mem.dataMem[0], dut.u_mem.dataMem[1023]); end
    rst = 1'b0;
  endtask

  task automatic test_sw_lb_lh();
    drive(MEM_SW, 32'h0, 32'h1234_5678, 5'd0, 1'b0, REG_SRC_ALU, 32'h40);
    step();
    total++; if (dut.u_mem.dataMem[0] !== 32'h1234_5678) begin bad++; $display("FAIL sw_word got=%h exp=12345678", dut.u_mem.dataMem[0]); end
    total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL sw_rd0_rw got=%0b exp=0", wb_reg_write); end
    drive(MEM_LB, 32'h3, 32'h0, 5'd5, 1'b1, REG_SRC_LOAD, 32'h44);
    step();
    total++; if (wb_write_data !== 32'h0000_0012) begin bad++; $display("FAIL lb3 got=%h exp=00000012", wb_write_data); end
    total++; if (wb_reg_write !== 1'b1 || wb_rd !== 5'd5 || wb_pc !== 32'h44) begin bad++; $display("FAIL lb3_fields rw=%0b rd=%0d pc=%h exp=1/5/44", wb_reg_write, wb_rd, wb_pc); end
    drive(MEM_LH, 32'h2, 32'h0, 5'd5, 1'b1, REG_SRC_LOAD, 32'h48);
    step();
    total++; if (wb_write_data !== 32'h0000_1234) begin bad++; $display("FAIL lh2 got=%h exp=00001234", wb_write_data); end
    drive(MEM_LW, 32'h0, 32'h0, 5'd6, 1'b1, REG_SRC_LOAD, 32'h4C);
    step();
    total++; if (wb_write_data !== 32'h1234_5678) begin bad++; $display("FAIL lw0 got=%h exp=12345678", wb_write_data); end
  endtask

  task automatic test_sb();
    drive(MEM_SB, 32'h5, 32'hABCD_EFFF, 5'd0, 1'b0, REG_SRC_ALU, 32'h50);
    step();
    total++; if (dut.u_mem.dataMem[1] !== 32'h0000_FF00) begin bad++; $display("FAIL sb_word got=%h exp=0000ff00", dut.u_mem.dataMem[1]); end
    total++; if (dut.u_mem.dataMem[0] !== 32'h1234_5678) begin bad++; $display("FAIL sb_neighbour got=%h exp=12345678", dut.u_mem.dataMem[0]); end
    drive(MEM_LB, 32'h5, 32'h0, 5'd1, 1'b1, REG_SRC_LOAD, 32'h54);
    step();
    total++; if (wb_write_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL lb5 got=%h exp=ffffffff", wb_write_data); end
    drive(MEM_LBU, 32'h5, 32'h0, 5'd1, 1'b1, REG_SRC_LOAD, 32'h58);
    step();
    total++; if (wb_write_data !== 32'h0000_00FF) begin bad++; $display("FAIL lbu5 got=%h exp=000000ff", wb_write_data); end
  endtask

  task automatic test_sh();
    drive(MEM_SH, 32'h8, 32'h7777_8001, 5'd0, 1'b0, REG_SRC_ALU, 32'h60);
    step();
    total++; if (dut.u_mem.dataMem[2] !== 32'h0000_8001) begin bad++; $display("FAIL sh_word got=%h exp=00008001", dut.u_mem.dataMem[2]); end
    drive(MEM_LH, 32'h8, 32'h0, 5'd2, 1'b1, REG_SRC_LOAD, 32'h64);
    step();
    total++; if (wb_write_data !== 32'hFFFF_8001) begin bad++; $display("FAIL lh8 got=%h exp=ffff8001", wb_write_data); end
    drive(MEM_LHU, 32'h8, 32'h0, 5'd2, 1'b1, REG_SRC_LOAD, 32'h68);
    step();
    total++; if (wb_write_data !== 32'h0000_8001) begin bad++; $display("FAIL lhu8 got=%h exp=00008001", wb_write_data); end
  endtask

  task automatic test_wb_src();
    drive(MEM_NONE, 32'hDEAD_BEEF, 32'h0, 5'd3, 1'b1, REG_SRC_ALU, 32'h70);
    step();
    total++; if (wb_write_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL src_alu got=%h exp=deadbeef", wb_write_data); end
    drive(MEM_NONE, 32'h0, 32'h0, 5'd31, 1'b1, REG_SRC_PC4, 32'h100);
    step();
    total++; if (wb_write_data !== 32'h104 || wb_pc !== 32'h100 || wb_rd !== 5'd31) begin bad++; $display("FAIL src_pc4 data=%h pc=%h rd=%0d exp=104/100/31", wb_write_data, wb_pc, wb_rd); end
    drive(MEM_NONE, 32'h1111_1111, 32'h0, 5'd3, 1'b1, 2'd3, 32'h74);
    step();
    total++; if (wb_write_data !== 32'h0) begin bad++; $display("FAIL src3 got=%h exp=0", wb_write_data); end
    drive(MEM_NONE, 32'h5, 32'h0, 5'd0, 1'b1, REG_SRC_ALU, 32'h78);
    step();
    total++; if (wb_reg_write !== 1'b0 || wb_valid !== 1'b1) begin bad++; $display("FAIL rd0 rw=%0b valid=%0b exp=0/1", wb_reg_write, wb_valid); end
    drive(MEM_NONE, 32'h5, 32'h0, 5'd4, 1'b1, REG_SRC_ALU, 32'h7C);
    mem_valid = 1'b0;
    step();
    total++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin bad++; $display("FAIL bubble valid=%0b rw=%0b exp=0/0", wb_valid, wb_reg_write); end
  endtask

  task automatic test_stall_flush();
    drive(MEM_NONE, 32'hAAAA_5555, 32'h0, 5'd7, 1'b1, REG_SRC_ALU, 32'h80);
    step();
    total++; if (wb_write_data !== 32'hAAAA_5555) begin bad++; $display("FAIL pre_stall got=%h exp=aaaa5555", wb_write_data); end
    drive(MEM_SW, 32'hC, 32'hCAFE_F00D, 5'd0, 1'b0, REG_SRC_ALU, 32'h84);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (dut.u_mem.dataMem[3] !== 32'h0) begin bad++; $display("FAIL stall_mem cyc=%0d got=%h exp=0", i, dut.u_mem.dataMem[3]); end
      total++; if (wb_write_data !== 32'hAAAA_5555 || wb_rd !== 5'd7 || wb_valid !== 1'b1 || wb_pc !== 32'h80) begin bad++; $display("FAIL stall_hold cyc=%0d data=%h rd=%0d v=%0b pc=%h exp=aaaa5555/7/1/80", i, wb_write_data, wb_rd, wb_valid, wb_pc); end
    end
    stall = 1'b0;
    step();
    total++; if (dut.u_mem.dataMem[3] !== 32'hCAFE_F00D) begin bad++; $display("FAIL release_mem got=%h exp=cafef00d", dut.u_mem.dataMem[3]); end
    total++; if (wb_pc !== 32'h84 || wb_reg_write !== 1'b0) begin bad++; $display("FAIL release_wb pc=%h rw=%0b exp=84/0", wb_pc, wb_reg_write); end
    drive(MEM_SW, 32'hC, 32'h0BAD_0BAD, 5'd0, 1'b0, REG_SRC_ALU, 32'h88);
    mem_valid = 1'b0;
    step();
    total++; if (dut.u_mem.dataMem[3] !== 32'hCAFE_F00D) begin bad++; $display("FAIL invalid_store got=%h exp=cafef00d", dut.u_mem.dataMem[3]); end
    drive(MEM_SW, 32'hC, 32'h1111_1111, 5'd9, 1'b1, REG_SRC_ALU, 32'h8C);
    stall = 1'b1;
    flush = 1'b1;
    step();
    total++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin bad++; $display("FAIL stall_flush valid=%0b rw=%0b exp=0/0", wb_valid, wb_reg_write); end
    total++; if (dut.u_mem.dataMem[3] !== 32'hCAFE_F00D) begin bad++; $display("FAIL stall_flush_mem got=%h exp=cafef00d", dut.u_mem.dataMem[3]); end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive(MEM_SW, 32'h10, 32'h5A5A_A5A5, 5'd0, 1'b0, REG_SRC_ALU, 32'h90);
    step();
    drive(MEM_LW, 32'h10, 32'h0, 5'd2, 1'b1, REG_SRC_LOAD, 32'h94);
    step();
    total++; if (wb_write_data !== 32'h5A5A_A5A5) begin bad++; $display("FAIL b2b_lw got=%h exp=5a5aa5a5", wb_write_data); end
    drive(MEM_SB, 32'h11, 32'h0000_003C, 5'd0, 1'b0, REG_SRC_ALU, 32'h98);
    step();
    drive(MEM_LW, 32'h10, 32'h0, 5'd2, 1'b1, REG_SRC_LOAD, 32'h9C);
    step();
    total++; if (wb_write_data !== 32'h5A5A_3CA5) begin bad++; $display("FAIL b2b_sb_lw got=%h exp=5a5a3ca5", wb_write_data); end
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    drive(MEM_LW, 32'h2, 32'h0, 5'd4, 1'b1, REG_SRC_LOAD, 32'hA0);
    step();
    total++; if (wb_misaligned !== 1'b1 || wb_reg_write !== 1'b0) begin bad++; $display("FAIL trap_lw mis=%0b rw=%0b exp=1/0", wb_misaligned, wb_reg_write); end
    drive(MEM_SW, 32'h1, 32'hFFFF_FFFF, 5'd0, 1'b0, REG_SRC_ALU, 32'hA4);
    step();
    total++; if (dut.u_mem.dataMem[0] !== 32'h1234_5678 || wb_misaligned !== 1'b1) begin bad++; $display("FAIL trap_sw mem=%h mis=%0b exp=12345678/1", dut.u_mem.dataMem[0], wb_misaligned); end
    drive(MEM_LW, 32'h0, 32'h0, 5'd4, 1'b1, REG_SRC_LOAD, 32'hA8);
    step();
    total++; if (wb_misaligned !== 1'b0 || wb_reg_write !== 1'b1 || wb_write_data !== 32'h1234_5678) begin bad++; $display("FAIL trap_clear mis=%0b rw=%0b data=%h exp=0/1/12345678", wb_misaligned, wb_reg_write, wb_write_data); end
`else
    drive(MEM_LW, 32'h2, 32'h0, 5'd4, 1'b1, REG_SRC_LOAD, 32'hA0);
    step();
    total++; if (wb_write_data !== 32'h1234_5678 || wb_misaligned !== 1'b0 || wb_reg_write !== 1'b1) begin bad++; $display("FAIL align_lw data=%h mis=%0b rw=%0b exp=12345678/0/1", wb_write_data, wb_misaligned, wb_reg_write); end
    drive(MEM_LH, 32'h3, 32'h0, 5'd4, 1'b1, REG_SRC_LOAD, 32'hA4);
    step();
    total++; if (wb_write_data !== 32'h0000_1234) begin bad++; $display("FAIL align_lh got=%h exp=00001234", wb_write_data); end
    drive(MEM_SW, 32'h15, 32'hDEAD_BEEF, 5'd0, 1'b0, REG_SRC_ALU, 32'hA8);
    step();
    total++; if (dut.u_mem.dataMem[5] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL align_sw got=%h exp=deadbeef", dut.u_mem.dataMem[5]); end
`endif
  endtask

  task automatic test_reset_midstream();
    drive(MEM_NONE, 32'h77, 32'h0, 5'd3, 1'b1, REG_SRC_ALU, 32'hB0);
    step();
    total++; if (wb_valid !== 1'b1 || wb_write_data !== 32'h77) begin bad++; $display("FAIL pre_rst valid=%0b data=%h exp=1/77", wb_valid, wb_write_data); end
    drive(MEM_SW, 32'h18, 32'h9999_9999, 5'd0, 1'b0, REG_SRC_ALU, 32'hB4);
    #2;
    rst = 1'b1;
    #1;
    total++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || wb_write_data !== 32'h0 || wb_pc !== 32'h0 || wb_rd !== 5'd0) begin bad++; $display("FAIL async_rst v=%0b rw=%0b data=%h pc=%h rd=%0d exp=0", wb_valid, wb_reg_write, wb_write_data, wb_pc, wb_rd); end
    step();
    total++; if (dut.u_mem.dataMem[6] !== 32'h0) begin bad++; $display("FAIL rst_store got=%h exp=0", dut.u_mem.dataMem[6]); end
    total++; if (dut.u_mem.dataMem[0] !== 32'h1234_5678 || dut.u_mem.dataMem[3] !== 32'hCAFE_F00D) begin bad++; $display("FAIL rst_retain got=%h/%h exp=12345678/cafef00d", dut.u_mem.dataMem[0], dut.u_mem.dataMem[3]); end
    #3;
    rst = 1'b0;
    mem_valid = 1'b0;
    step();
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    flush          = 1'b0;
    mem_valid      = 1'b0;
    mem_pc         = 32'h0;
    mem_alu_result = 32'h0;
    mem_store_data = 32'h0;
    mem_op         = 4'd0;
    mem_reg_write  = 1'b0;
    mem_reg_src    = 2'd0;
    mem_rd         = 5'd0;
    test_reset();
    test_sw_lb_lh();
    test_sb();
    test_sh();
    test_wb_src();
    test_stall_flush();
    test_back_to_back();
    test_misalign();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
